// File: rtl/pipeline_pkg.sv
// Shared definitions for the VLIW pipeline front end.
// Contents: redirect select codes, default NOP slot encoding,
// and the instruction-fetch state enumeration.
package pipeline_pkg;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_VECTOR = 2'b11;

  localparam logic [15:0] DEFAULT_NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DROP  = 2'b10
  } fetchState_t;

endpackage

// File: rtl/if_stage_pcTargetMux.sv
// pcTargetMux: combinational redirect-target computation for the fetch stage.
// Ports:
//   pcSrc        - redirect select (seq / branch / jump / vector)
//   p1Pc         - PC of the bundle in IF/ID (jump base)
//   jumpOffset   - jump offset relative to p1Pc
//   p2Pc         - PC of the bundle in EX (branch base)
//   branchOffset - branch offset relative to p2Pc
//   redirect     - 1 when pcSrc selects a non-sequential target
//   target       - 4-aligned redirect target (modulo-2^32 sums)
module pcTargetMux
  import pipeline_pkg::*;
#(
  parameter logic [31:0] VECTOR_PC = 32'h0000_0040
) (
  input  logic [1:0]  pcSrc,
  input  logic [31:0] p1Pc,
  input  logic [31:0] jumpOffset,
  input  logic [31:0] p2Pc,
  input  logic [31:0] branchOffset,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] rawTarget;

  always_comb begin
    rawTarget = '0;
    unique case (pcSrc)
      PCSRC_BRANCH: rawTarget = p2Pc + branchOffset;
      PCSRC_JUMP:   rawTarget = p1Pc + jumpOffset;
      PCSRC_VECTOR: rawTarget = VECTOR_PC;
      default:      rawTarget = '0;
    endcase
  end

  assign redirect = (pcSrc != PCSRC_SEQ);
  assign target   = {rawTarget[31:2], 2'b00};

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch for the two-slot VLIW pipeline.
// Owns the PC, fetches 32-bit bundles over a req/ready handshake, holds one
// bundle in a skid buffer while ID stalls, and loads the IF/ID register.
// Ports:
//   clk, reset (async, active-low)
//   p1_pipeline_regWrite - IF/ID write enable (0 = ID stalled)
//   pcSrc, IF_flush      - redirect select / IF/ID flush from ID
//   mem_shiftedSext11_jumpOffset, p2_pc, p2_mem_shiftedSext8_branchOffset
//                        - redirect target operands
//   imem_req, imem_addr, imem_ready, imem_rdata - instruction memory port
//   p1_aluInstr, p1_memInstr, p1_pc, p1_valid   - IF/ID pipeline register
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] VECTOR_PC = 32'h0000_0040,
  parameter logic [15:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p1_pipeline_regWrite,
  input  logic [1:0]  pcSrc,
  input  logic        IF_flush,
  input  logic [31:0] mem_shiftedSext11_jumpOffset,
  input  logic [31:0] p2_pc,
  input  logic [31:0] p2_mem_shiftedSext8_branchOffset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [15:0] p1_aluInstr,
  output logic [15:0] p1_memInstr,
  output logic [31:0] p1_pc,
  output logic        p1_valid
);

  fetchState_t state, stateNext;
  logic [31:0] pc, pcNext;
  logic [31:0] reqAddr, reqAddrNext;
  logic        bufValid, bufValidNext;
  logic [31:0] bufInstr;
  logic [31:0] bufPc;

  logic        redirect;
  logic [31:0] target;
  logic        complete;
  logic        drain;
  logic        waiting;

  pcTargetMux #(
    .VECTOR_PC(VECTOR_PC)
  ) uTargetMux (
    .pcSrc       (pcSrc),
    .p1Pc        (p1_pc),
    .jumpOffset  (mem_shiftedSext11_jumpOffset),
    .p2Pc        (p2_pc),
    .branchOffset(p2_mem_shiftedSext8_branchOffset),
    .redirect    (redirect),
    .target      (target)
  );

  assign imem_req  = ((state == FETCH) && !bufValid) || (state == DROP);
  assign imem_addr = reqAddr;

  // A request still waiting on memory must keep its address stable.
  assign waiting  = imem_req && !imem_ready;
  assign complete = (state == FETCH) && !bufValid && imem_ready && !redirect;
  assign drain    = bufValid && p1_pipeline_regWrite && !redirect;

  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    bufValidNext = bufValid;

    unique case (state)
      IDLE:    stateNext = FETCH;
      FETCH:   if (redirect && waiting) stateNext = DROP;
      DROP:    if (imem_ready) stateNext = FETCH;
      default: stateNext = IDLE;
    endcase

    if (redirect) begin
      pcNext       = target;
      bufValidNext = 1'b0;
    end else if (complete) begin
      pcNext       = pc + 32'd4;
      // A flushed completion is dropped rather than buffered.
      bufValidNext = !p1_pipeline_regWrite && !IF_flush;
    end else if (drain) begin
      bufValidNext = 1'b0;
    end

    reqAddrNext = waiting ? reqAddr : pcNext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      reqAddr  <= RESET_PC;
      bufValid <= 1'b0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      reqAddr  <= reqAddrNext;
      bufValid <= bufValidNext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bufInstr <= '0;
      bufPc    <= '0;
    end else if (complete && !p1_pipeline_regWrite) begin
      bufInstr <= imem_rdata;
      bufPc    <= reqAddr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_aluInstr <= NOP_INSTR;
      p1_memInstr <= NOP_INSTR;
      p1_pc       <= '0;
      p1_valid    <= 1'b0;
    end else if (IF_flush) begin
      p1_aluInstr <= NOP_INSTR;
      p1_memInstr <= NOP_INSTR;
      p1_valid    <= 1'b0;
    end else if (complete && p1_pipeline_regWrite) begin
      p1_aluInstr <= imem_rdata[31:16];
      p1_memInstr <= imem_rdata[15:0];
      p1_pc       <= reqAddr;
      p1_valid    <= 1'b1;
    end else if (drain) begin
      p1_aluInstr <= bufInstr[31:16];
      p1_memInstr <= bufInstr[15:0];
      p1_pc       <= bufPc;
      p1_valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] VEC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite;
  logic [1:0]  pcSrc;
  logic        flush;
  logic [31:0] jOff, p2Pc, brOff;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;
  logic [15:0] alu, mem;
  logic [31:0] p1Pc;
  logic        valid;

  int checks = 0;
  int errors = 0;

  // Reference model: fetch progress, pending-drop flag and a queue buffer.
  bit          mStarted, mDropping;
  logic [31:0] mPc, mReqAddr, mP1Pc;
  logic [15:0] mAlu, mMem;
  bit          mValid;
  logic [63:0] mBuf[$];

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .VECTOR_PC(VEC),
    .NOP_INSTR(16'h0000)
  ) dut (
    .clk                             (clk),
    .reset                           (reset),
    .p1_pipeline_regWrite            (regWrite),
    .pcSrc                           (pcSrc),
    .IF_flush                        (flush),
    .mem_shiftedSext11_jumpOffset    (jOff),
    .p2_pc                           (p2Pc),
    .p2_mem_shiftedSext8_branchOffset(brOff),
    .imem_req                        (req),
    .imem_addr                       (addr),
    .imem_ready                      (ready),
    .imem_rdata                      (rdata),
    .p1_aluInstr                     (alu),
    .p1_memInstr                     (mem),
    .p1_pc                           (p1Pc),
    .p1_valid                        (valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mStarted  = 0;
    mDropping = 0;
    mPc       = 32'h0;
    mReqAddr  = 32'h0;
    mP1Pc     = 32'h0;
    mAlu      = 16'h0;
    mMem      = 16'h0;
    mValid    = 0;
    mBuf.delete();
  endtask

  function automatic bit modelReq();
    return mStarted && (mDropping || mBuf.size() == 0);
  endfunction

  task automatic modelStep();
    bit          rq, redir, complete, drain;
    logic [31:0] tgt, pcN;
    logic [63:0] e;
    rq    = modelReq();
    redir = (pcSrc != 2'b00);
    case (pcSrc)
      2'b01:   tgt = p2Pc + brOff;
      2'b10:   tgt = mP1Pc + jOff;
      default: tgt = VEC;
    endcase
    tgt      = tgt & 32'hFFFF_FFFC;
    complete = rq && !mDropping && ready && !redir;
    drain    = (mBuf.size() != 0) && regWrite && !redir;
    pcN      = mPc;
    if (redir) begin
      pcN = tgt;
      mBuf.delete();
      mDropping = rq && !ready;
    end else begin
      mDropping = mDropping && !ready;
      if (complete) begin
        pcN = mPc + 32'd4;
        if (!flush) begin
          if (regWrite) begin
            mAlu = rdata[31:16]; mMem = rdata[15:0]; mP1Pc = mReqAddr; mValid = 1;
          end else begin
            mBuf.push_back({rdata, mReqAddr});
          end
        end
      end else if (drain) begin
        e = mBuf.pop_front();
        if (!flush) begin
          mAlu = e[63:48]; mMem = e[47:32]; mP1Pc = e[31:0]; mValid = 1;
        end
      end
    end
    if (flush) begin
      mAlu = 16'h0; mMem = 16'h0; mValid = 0;
    end
    if (!(rq && !ready)) mReqAddr = pcN;
    mPc      = pcN;
    mStarted = 1;
  endtask

  // One clock: check the fetch port mid-cycle, advance the model on the
  // edge, then check the registered IF/ID outputs just after it.
  task automatic tick();
    @(negedge clk);
    chk("imem_req", {31'b0, req}, {31'b0, modelReq()});
    chk("imem_addr", addr, mReqAddr);
    @(posedge clk);
    modelStep();
    #1;
    chk("p1_aluInstr", {16'b0, alu}, {16'b0, mAlu});
    chk("p1_memInstr", {16'b0, mem}, {16'b0, mMem});
    chk("p1_pc", p1Pc, mP1Pc);
    chk("p1_valid", {31'b0, valid}, {31'b0, mValid});
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_req"}, {31'b0, req}, 32'h0);
    chk({tag, "_addr"}, addr, 32'h0);
    chk({tag, "_alu"}, {16'b0, alu}, 32'h0);
    chk({tag, "_mem"}, {16'b0, mem}, 32'h0);
    chk({tag, "_p1pc"}, p1Pc, 32'h0);
    chk({tag, "_valid"}, {31'b0, valid}, 32'h0);
  endtask

  initial begin
    int guard;
    reset    = 1'b0;
    regWrite = 1'b1;
    pcSrc    = 2'b00;
    flush    = 1'b0;
    jOff     = 32'h0;
    p2Pc     = 32'h0;
    brOff    = 32'h0;
    ready    = 1'b1;
    rdata    = 32'hA1B2_C3D4;
    modelReset();

    #12;
    checkResetOutputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // Reset/stream
    tick();                                   // IDLE cycle
    chk("first_req", {31'b0, req}, 32'h1);
    chk("first_addr", addr, 32'h0);
    tick();                                   // bundle at 0x0
    chk("stream_alu", {16'b0, alu}, 32'hA1B2);
    chk("stream_mem", {16'b0, mem}, 32'hC3D4);
    chk("stream_pc0", p1Pc, 32'h0);
    rdata = $urandom;
    tick();
    chk("stream_pc4", p1Pc, 32'h4);

    // Stall/skid: bundle at 0x8 returns while ID is stalled
    regWrite = 1'b0;
    rdata = $urandom;
    tick();
    chk("stall_hold_pc", p1Pc, 32'h4);
    chk("stall_no_req", {31'b0, req}, 32'h0);
    tick();
    tick();
    chk("stall_hold_pc2", p1Pc, 32'h4);
    regWrite = 1'b1;
    tick();
    chk("drain_pc8", p1Pc, 32'h8);
    chk("drain_addrC", addr, 32'hC);
    chk("drain_reqC", {31'b0, req}, 32'h1);
    rdata = $urandom;
    tick();
    rdata = $urandom;
    tick();
    chk("at_pc10", p1Pc, 32'h10);

    // Jump with flush
    pcSrc = 2'b10; jOff = 32'h20; flush = 1'b1; rdata = $urandom;
    tick();
    chk("jump_valid", {31'b0, valid}, 32'h0);
    chk("jump_alu", {16'b0, alu}, 32'h0);
    chk("jump_addr", addr, 32'h30);
    pcSrc = 2'b00; flush = 1'b0;

    // Branch while the 0x30 request waits
    ready = 1'b0;
    tick();
    pcSrc = 2'b01; p2Pc = 32'h8; brOff = 32'hFFFF_FFFC;
    tick();
    chk("drop_addr_held", addr, 32'h30);
    pcSrc = 2'b00; ready = 1'b1; rdata = $urandom;
    tick();
    chk("branch_addr", addr, 32'h4);
    tick();
    chk("branch_pc", p1Pc, 32'h4);

    // Vector, then wrap from 0xFFFF_FFFC
    pcSrc = 2'b11;
    tick();
    chk("vector_addr", addr, 32'h40);
    pcSrc = 2'b01; p2Pc = 32'h0; brOff = 32'hFFFF_FFFC;
    tick();
    chk("wrap_addr_top", addr, 32'hFFFF_FFFC);
    pcSrc = 2'b00; rdata = $urandom;
    tick();
    chk("wrap_addr_zero", addr, 32'h0);

    // Randomized phase against the model
    for (int i = 0; i < 600; i++) begin
      ready    = ($urandom_range(0, 99) < 70);
      regWrite = ($urandom_range(0, 99) < 75);
      rdata    = $urandom;
      if ($urandom_range(0, 99) < 8) begin
        pcSrc = 2'($urandom_range(1, 3));
        flush = $urandom_range(0, 1);
      end else begin
        pcSrc = 2'b00;
        flush = ($urandom_range(0, 99) < 3);
      end
      jOff  = $urandom;
      p2Pc  = $urandom;
      brOff = $urandom;
      tick();
    end

    // Async reset while a bundle sits in the skid buffer
    pcSrc = 2'b00; flush = 1'b0; regWrite = 1'b0; ready = 1'b1;
    guard = 0;
    while (mBuf.size() == 0 && guard < 20) begin
      rdata = $urandom;
      tick();
      guard++;
    end
    chk("skid_filled_no_req", {31'b0, req}, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    modelReset();
    @(posedge clk); #1;
    reset = 1'b1;
    regWrite = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
